// File: rtl/mmio_write_router.sv
// ---------------------------------------------------------------------------
// mmio_write_router
//
// Splits the CPU store path between data memory and a bank of NCH memory-
// mapped peripheral channels. An IO store is decoded by base/stride into a
// channel index and posted into that channel's holding register. The channel
// then presents the write with a valid/ack handshake. The CPU is held only
// when it stores to a channel whose previous write is still unacknowledged.
// Unmapped or misaligned IO stores are dropped and logged in a sticky error
// register. The error register keeps the address of the first such store.
//
// Ports:
//   clk       in   1            single clock, all state on rising edge
//   rst_n     in   1            synchronous active-low reset
//   addr      in   32           CPU store byte address
//   wdata     in   DATA_W       CPU store data
//   we        in   1            CPU store strobe (held while stall=1)
//   dmem_we   out  1            data-memory write enable (combinational)
//   stall     out  1            CPU hold request (combinational)
//   ch_valid  out  NCH          per-channel write pending
//   ch_data   out  NCH*DATA_W   per-channel held data, channel i at [i*DATA_W +: DATA_W]
//   ch_ack    in   NCH          per-channel accept pulse
//   err       out  1            sticky unmapped-write flag
//   err_addr  out  ADDR_W       address of the first unmapped write since clear
//   err_clr   in   1            clears err and err_addr
// ---------------------------------------------------------------------------
module mmio_write_router #(
    parameter int                NCH    = 16,
    parameter int                ADDR_W = 15,
    parameter int                IO_BIT = 14,
    parameter logic [ADDR_W-1:0] BASE   = 15'h4000,
    parameter int                STRIDE = 4,
    parameter int                DATA_W = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [31:0]             addr,
    input  logic [DATA_W-1:0]       wdata,
    input  logic                    we,
    output logic                    dmem_we,
    output logic                    stall,
    output logic [NCH-1:0]          ch_valid,
    output logic [NCH*DATA_W-1:0]   ch_data,
    input  logic [NCH-1:0]          ch_ack,
    output logic                    err,
    output logic [ADDR_W-1:0]       err_addr,
    input  logic                    err_clr
);

    // STRIDE is a power of two, so divide/modulo reduce to a shift and a mask.
    localparam int SH    = $clog2(STRIDE);
    localparam int IDX_W = ADDR_W - SH;

    logic                  io_s;
    logic [ADDR_W-1:0]     off_s;
    logic [IDX_W-1:0]      idx_s;
    logic                  aligned_s;
    logic [NCH-1:0]        sel_raw_s;
    logic                  hit_s;
    logic [NCH-1:0]        sel_s;
    logic                  stall_s;
    logic [NCH-1:0]        take_s;
    logic                  err_set_s;
    logic                  dmem_we_s;

    logic [NCH-1:0]        ch_valid_r;
    logic [NCH*DATA_W-1:0] ch_data_r;
    logic                  err_r;
    logic [ADDR_W-1:0]     err_addr_r;

    // Upper address bits take no part in decoding.
    logic                  unused_addr_s;
    assign unused_addr_s = ^addr[31:ADDR_W];

    // Window/channel decode, stall and per-channel take strobes.
    always_comb begin
        io_s      = addr[IO_BIT];
        // Wrap-around subtraction: an address below BASE yields a huge index
        // that no channel matches, so it lands in the error path.
        off_s     = addr[ADDR_W-1:0] - BASE;
        idx_s     = off_s[ADDR_W-1:SH];
        aligned_s = (off_s[SH-1:0] == {SH{1'b0}});
        sel_raw_s = {NCH{1'b0}};
        for (int i = 0; i < NCH; i++) begin
            sel_raw_s[i] = (idx_s == IDX_W'(i));
        end
        // Some channel matching the index is equivalent to idx < NCH.
        hit_s     = io_s & aligned_s & (|sel_raw_s);
        sel_s     = hit_s ? sel_raw_s : {NCH{1'b0}};
        // An ack in the same cycle frees the slot, so it does not block.
        stall_s   = we & (|(sel_s & ch_valid_r & ~ch_ack));
        take_s    = (we & ~stall_s) ? sel_s : {NCH{1'b0}};
        err_set_s = we & io_s & ~hit_s;
        dmem_we_s = we & ~io_s;
    end

    // Per-channel holding registers and valid flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ch_valid_r <= {NCH{1'b0}};
            ch_data_r  <= {(NCH*DATA_W){1'b0}};
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (take_s[i]) begin
                    // New write wins over a same-cycle ack: back-to-back.
                    ch_data_r[i*DATA_W +: DATA_W] <= wdata;
                    ch_valid_r[i]                 <= 1'b1;
                end else if (ch_ack[i]) begin
                    ch_valid_r[i] <= 1'b0;
                end else begin
                    ch_valid_r[i] <= ch_valid_r[i];
                end
            end
        end
    end

    // Sticky error flag; the address of the first error is kept until clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_r      <= 1'b0;
            err_addr_r <= {ADDR_W{1'b0}};
        end else if (err_clr) begin
            err_r      <= 1'b0;
            err_addr_r <= {ADDR_W{1'b0}};
        end else if (err_set_s) begin
            err_r <= 1'b1;
            if (!err_r) begin
                err_addr_r <= addr[ADDR_W-1:0];
            end else begin
                err_addr_r <= err_addr_r;
            end
        end else begin
            err_r      <= err_r;
            err_addr_r <= err_addr_r;
        end
    end

    assign dmem_we  = dmem_we_s;
    assign stall    = stall_s;
    assign ch_valid = ch_valid_r;
    assign ch_data  = ch_data_r;
    assign err      = err_r;
    assign err_addr = err_addr_r;

endmodule

// File: tb/tb_mmio_write_router.sv
// ---------------------------------------------------------------------------
// tb_mmio_write_router
//
// Directed bench for mmio_write_router. A default-parameter instance covers
// reset, the DMEM/IO split, stall/release, channel independence and error
// logging. A second instance (NCH=4, STRIDE=16, BASE=15'h4100) covers the
// decode with non-default parameters. Inputs change on the falling edge.
// Combinational outputs are sampled 1 ns later, and registered outputs are
// sampled on the following falling edge.
// ---------------------------------------------------------------------------
module tb_mmio_write_router;

    logic              clk;
    logic              rst_n;

    // default instance
    logic [31:0]       d_addr;
    logic [31:0]       d_wdata;
    logic              d_we;
    logic              d_dmem_we;
    logic              d_stall;
    logic [15:0]       d_ch_valid;
    logic [16*32-1:0]  d_ch_data;
    logic [15:0]       d_ch_ack;
    logic              d_err;
    logic [14:0]       d_err_addr;
    logic              d_err_clr;

    // swept-parameter instance
    logic [31:0]       s_addr;
    logic [31:0]       s_wdata;
    logic              s_we;
    logic              s_dmem_we;
    logic              s_stall;
    logic [3:0]        s_ch_valid;
    logic [4*32-1:0]   s_ch_data;
    logic [3:0]        s_ch_ack;
    logic              s_err;
    logic [14:0]       s_err_addr;
    logic              s_err_clr;

    int                total;
    int                bad;

    mmio_write_router dut_d (
        .clk      (clk),
        .rst_n    (rst_n),
        .addr     (d_addr),
        .wdata    (d_wdata),
        .we       (d_we),
        .dmem_we  (d_dmem_we),
        .stall    (d_stall),
        .ch_valid (d_ch_valid),
        .ch_data  (d_ch_data),
        .ch_ack   (d_ch_ack),
        .err      (d_err),
        .err_addr (d_err_addr),
        .err_clr  (d_err_clr)
    );

    mmio_write_router #(
        .NCH    (4),
        .STRIDE (16),
        .BASE   (15'h4100)
    ) dut_s (
        .clk      (clk),
        .rst_n    (rst_n),
        .addr     (s_addr),
        .wdata    (s_wdata),
        .we       (s_we),
        .dmem_we  (s_dmem_we),
        .stall    (s_stall),
        .ch_valid (s_ch_valid),
        .ch_data  (s_ch_data),
        .ch_ack   (s_ch_ack),
        .err      (s_err),
        .err_addr (s_err_addr),
        .err_clr  (s_err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        if (obs !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        rst_n     = 1'b0;
        d_addr    = 32'h0000_4004;
        d_wdata   = 32'h1234_5678;
        d_we      = 1'b1;
        d_ch_ack  = 16'h0000;
        d_err_clr = 1'b0;
        s_addr    = 32'h0000_0000;
        s_wdata   = 32'h0000_0000;
        s_we      = 1'b0;
        s_ch_ack  = 4'h0;
        s_err_clr = 1'b0;

        // ---- reset held 2 cycles with a store to 0x4004 ----
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            check_eq("rst_dmem_we", {31'd0, d_dmem_we}, 32'd0);
            check_eq("rst_stall",   {31'd0, d_stall},   32'd0);
            check_eq("rst_valid",   {16'd0, d_ch_valid}, 32'd0);
        end
        rst_n = 1'b1;
        d_we  = 1'b0;
        @(negedge clk);
        check_eq("post_rst_valid", {16'd0, d_ch_valid}, 32'd0);
        check_eq("post_rst_err",   {31'd0, d_err},      32'd0);
        check_eq("post_rst_ch1",   d_ch_data[1*32 +: 32], 32'd0);
        check_eq("post_rst_s_err", {31'd0, s_err},      32'd0);

        // ---- DMEM store ----
        d_we   = 1'b1;
        d_addr = 32'h0000_0100;
        #1;
        check_eq("dmem_we_hi", {31'd0, d_dmem_we}, 32'd1);
        check_eq("dmem_stall", {31'd0, d_stall},   32'd0);
        @(negedge clk);
        d_we = 1'b0;
        check_eq("dmem_no_valid", {16'd0, d_ch_valid}, 32'd0);
        check_eq("dmem_no_err",   {31'd0, d_err},      32'd0);

        // ---- IO store to channel 2 ----
        d_we    = 1'b1;
        d_addr  = 32'h0000_4008;
        d_wdata = 32'hDEAD_BEEF;
        #1;
        check_eq("io_dmem_we", {31'd0, d_dmem_we}, 32'd0);
        @(negedge clk);
        d_we = 1'b0;
        check_eq("io_valid",  {16'd0, d_ch_valid}, 32'h0000_0004);
        check_eq("io_data2",  d_ch_data[2*32 +: 32], 32'hDEAD_BEEF);
        // ack retires it, data retained
        d_ch_ack = 16'h0004;
        @(negedge clk);
        d_ch_ack = 16'h0000;
        check_eq("ack_valid", {16'd0, d_ch_valid}, 32'd0);
        check_eq("ack_data2", d_ch_data[2*32 +: 32], 32'hDEAD_BEEF);
        // stray ack on an idle channel is ignored
        d_ch_ack = 16'h0020;
        @(negedge clk);
        d_ch_ack = 16'h0000;
        check_eq("stray_ack", {16'd0, d_ch_valid}, 32'd0);

        // ---- stall and release on channel 3 ----
        d_we    = 1'b1;
        d_addr  = 32'h0000_400C;
        d_wdata = 32'h0000_0011;
        #1;
        check_eq("first_no_stall", {31'd0, d_stall}, 32'd0);
        @(negedge clk);
        check_eq("ch3_first", d_ch_data[3*32 +: 32], 32'h0000_0011);
        d_wdata = 32'h0000_0022;
        for (int c = 0; c < 3; c++) begin
            #1;
            check_eq("stall_cycle", {31'd0, d_stall}, 32'd1);
            check_eq("ch3_held",    d_ch_data[3*32 +: 32], 32'h0000_0011);
            if (c < 2) @(negedge clk);
        end
        d_ch_ack = 16'h0008;
        #1;
        check_eq("stall_ack", {31'd0, d_stall}, 32'd0);
        @(negedge clk);
        d_ch_ack = 16'h0000;
        d_we     = 1'b0;
        #1;
        check_eq("stall_after", {31'd0, d_stall}, 32'd0);
        check_eq("ch3_valid",   {31'd0, d_ch_valid[3]}, 32'd1);
        check_eq("ch3_second",  d_ch_data[3*32 +: 32], 32'h0000_0022);

        // ---- independence: ch0 pending, write ch4 ----
        @(negedge clk);
        d_we    = 1'b1;
        d_addr  = 32'h0000_4000;
        d_wdata = 32'h0000_00A0;
        @(negedge clk);
        check_eq("ch0_valid", {31'd0, d_ch_valid[0]}, 32'd1);
        d_addr  = 32'h0000_4010;
        d_wdata = 32'h0000_00B4;
        #1;
        check_eq("indep_no_stall", {31'd0, d_stall}, 32'd0);
        @(negedge clk);
        d_we = 1'b0;
        check_eq("indep_valid", {16'd0, d_ch_valid}, 32'h0000_0019);
        check_eq("ch4_data",    d_ch_data[4*32 +: 32], 32'h0000_00B4);
        check_eq("ch0_data",    d_ch_data[0*32 +: 32], 32'h0000_00A0);

        // ---- errors ----
        d_we   = 1'b1;
        d_addr = 32'h0000_4006;
        #1;
        check_eq("mis_dmem_we", {31'd0, d_dmem_we}, 32'd0);
        check_eq("mis_stall",   {31'd0, d_stall},   32'd0);
        @(negedge clk);
        check_eq("mis_err",      {31'd0, d_err},      32'd1);
        check_eq("mis_err_addr", {17'd0, d_err_addr}, 32'h0000_4006);
        check_eq("mis_no_take",  {16'd0, d_ch_valid}, 32'h0000_0019);
        d_addr = 32'h0000_4040;
        @(negedge clk);
        check_eq("oor_err",      {31'd0, d_err},      32'd1);
        check_eq("oor_err_addr", {17'd0, d_err_addr}, 32'h0000_4006);
        d_addr    = 32'h0000_7FFC;
        d_err_clr = 1'b1;
        @(negedge clk);
        d_err_clr = 1'b0;
        check_eq("clr_err",      {31'd0, d_err},      32'd0);
        check_eq("clr_err_addr", {17'd0, d_err_addr}, 32'd0);
        @(negedge clk);
        d_we = 1'b0;
        check_eq("recap_err",      {31'd0, d_err},      32'd1);
        check_eq("recap_err_addr", {17'd0, d_err_addr}, 32'h0000_7FFC);

        // ---- parameter sweep instance ----
        s_we    = 1'b1;
        s_addr  = 32'h0000_4130;
        s_wdata = 32'h0000_0033;
        @(negedge clk);
        check_eq("sw_valid", {28'd0, s_ch_valid}, 32'h0000_0008);
        check_eq("sw_data3", s_ch_data[3*32 +: 32], 32'h0000_0033);
        check_eq("sw_no_err", {31'd0, s_err}, 32'd0);
        s_addr = 32'h0000_4140;
        @(negedge clk);
        check_eq("sw_oor_err",  {31'd0, s_err},      32'd1);
        check_eq("sw_oor_addr", {17'd0, s_err_addr}, 32'h0000_4140);
        s_we      = 1'b0;
        s_err_clr = 1'b1;
        @(negedge clk);
        s_err_clr = 1'b0;
        check_eq("sw_clr", {31'd0, s_err}, 32'd0);
        s_we   = 1'b1;
        s_addr = 32'h0000_40F0;
        @(negedge clk);
        s_we = 1'b0;
        check_eq("sw_under_err",  {31'd0, s_err},      32'd1);
        check_eq("sw_under_addr", {17'd0, s_err_addr}, 32'h0000_40F0);
        check_eq("sw_under_valid", {28'd0, s_ch_valid}, 32'h0000_0008);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
